// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, branch redirect with a pending slot
// that holds a redirect arriving during a stall, and an alignment check
// that suppresses misaligned fetches.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC,
    parameter int unsigned STALL_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic [32:0]        br_bus,
    output logic [32:0]        if_to_id_bus,
    output logic               inst_sram_en,
    output logic [3:0]         inst_sram_wen,
    output logic [31:0]        inst_sram_addr,
    output logic [31:0]        inst_sram_wdata,
    output logic               fetch_adel,
    output logic [31:0]        fetch_cnt
);

    logic        br_e;
    logic [31:0] br_addr;
    logic        stop;

    logic [31:0] pc_q, pc_d;
    logic        ce_q, ce_d;
    logic        adel_q, adel_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] next_pc;

    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];
    assign stop    = stall[0];

    // Only bit 0 of the stall vector concerns this stage.
    logic unused_stall;
    assign unused_stall = ^stall[STALL_W-1:1];

    // Next-fetch selection: a live redirect beats a pending one.
    always_comb begin
        next_pc = pc_q + 32'd4;
        if (br_e) begin
            next_pc = br_addr;
        end else if (pend_v_q) begin
            next_pc = pend_addr_q;
        end
    end

    // Next-state: advance when not stalled, otherwise hold and capture redirects.
    always_comb begin
        pc_d        = pc_q;
        ce_d        = ce_q;
        adel_d      = adel_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        cnt_d       = cnt_q;
        if (!stop) begin
            pc_d     = next_pc;
            ce_d     = 1'b1;
            adel_d   = (next_pc[1:0] != 2'b00);
            pend_v_d = 1'b0;
            // Counts the fetch presented in this cycle; wraps naturally.
            if (inst_sram_en) begin
                cnt_d = cnt_q + 32'd1;
            end
        end else if (br_e) begin
            // A later redirect while stalled replaces the earlier one.
            pend_v_d    = 1'b1;
            pend_addr_d = br_addr;
        end
    end

    // State register with synchronous reset that dominates stall and redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            ce_q        <= 1'b0;
            adel_q      <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= 32'h0;
            cnt_q       <= 32'h0;
        end else begin
            pc_q        <= pc_d;
            ce_q        <= ce_d;
            adel_q      <= adel_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    // Outputs come straight from registers; no input reaches them combinationally.
    always_comb begin
        inst_sram_en    = ce_q & ~adel_q;
        inst_sram_wen   = 4'b0000;
        inst_sram_addr  = pc_q;
        inst_sram_wdata = 32'h0;
        if_to_id_bus    = {ce_q & ~adel_q, pc_q};
        fetch_adel      = adel_q & ce_q;
        fetch_cnt       = cnt_q;
    end

endmodule
